cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Sits directly downstream of the pipeline's split L1 caches.
- Merges I-cache and D-cache line-miss traffic onto the single physical-memory (cacheline adaptor) port.
- Grants one requester at a time and holds the grant until that transaction completes.
- D-cache has priority; a starvation counter guarantees the I-cache forward progress.

Parameters:
LINE_W, 256, cacheline width in bits
ADDR_W, 32, address width
STARVE_LIMIT, 4, consecutive D grants allowed while I is pending before I is forced

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
i_pmem_read  input  1  I-cache line fill request, level, held until i_pmem_resp
i_pmem_address  input  ADDR_W  I-cache line address
i_pmem_rdata  output  LINE_W  fill data to I-cache
i_pmem_resp  output  1  I transaction complete, one-cycle pulse
d_pmem_read  input  1  D-cache fill request, level, held until d_pmem_resp
d_pmem_write  input  1  D-cache writeback request, level, held until d_pmem_resp
d_pmem_address  input  ADDR_W  D-cache line address
d_pmem_wdata  input  LINE_W  writeback data
d_pmem_rdata  output  LINE_W  fill data to D-cache
d_pmem_resp  output  1  D transaction complete, one-cycle pulse
pmem_read  output  1  read request to memory
pmem_write  output  1  write request to memory
pmem_address  output  ADDR_W  latched granted address
pmem_wdata  output  LINE_W  latched writeback data
pmem_rdata  input  LINE_W  memory read data, valid with pmem_resp
pmem_resp  input  1  memory transaction done

Behaviour:
- Clock and reset are clk and rst_n: one clock; rst_n is asynchronous and active-low.
- States: IDLE, SERVE_I, SERVE_D, RECOVER.
- Reset (asynchronous, active-low):
  - state=IDLE, starve_cnt=0, latched address/wdata/op=0.
  - All outputs 0 immediately on assertion, including mid-transaction.
  - Any in-flight memory response is discarded.
- IDLE, arbitration, decided on the registered cycle:
  - D pending (d_pmem_read|d_pmem_write) and not (i_pmem_read && starve_cnt==STARVE_LIMIT) -> SERVE_D.
  - Else if i_pmem_read -> SERVE_I.
  - Else stay IDLE.
  - On the transition, latch address, wdata and op (write if d_pmem_write, else read).
- Illegal d_pmem_read&&d_pmem_write: write wins.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each D grant made while i_pmem_read=1.
  - Clears on any I grant, or on a D grant with i_pmem_read=0.
- SERVE_x:
  - pmem_read/pmem_write driven from latched op; pmem_address/pmem_wdata from latches.
  - Outputs are registered-state-derived, so the memory request asserts exactly 1 cycle after the request is first seen in IDLE.
- Response:
  - On pmem_resp in SERVE_x, the granted x_pmem_resp=1 combinationally in the same cycle.
  - x_pmem_rdata=pmem_rdata for that cycle; the non-granted resp stays 0.
  - Next state RECOVER.
- rdata outputs: both always carry pmem_rdata; only the resp qualifies them.
- RECOVER:
  - One bubble cycle; no memory request and no resp.
  - Lets the requester drop its level request so a stale request is not re-granted.
  - -> IDLE.
- Minimum round trip: request seen at cycle 0, pmem request at cycle 1, resp at cycle k≥1, next arbitration at cycle k+2.
- Requests that appear or drop while another requester is granted are ignored until IDLE.
- Address or data changes by the granted requester mid-transaction have no effect (latched).
- pmem_resp outside SERVE_x is ignored.

Test Plan:
- Single I miss: i_pmem_read=1, addr 0x0000_0040; mem resp after 5 cycles with rdata=pattern A -> pmem_read=1 at cycle 1, pmem_address=0x40, i_pmem_resp pulses 1 cycle with i_pmem_rdata=A, d_pmem_resp never 1.
- Simultaneous I read and D write, addr 0x80 and wdata B -> D served first (pmem_write=1, pmem_wdata=B); after RECOVER, I served with pmem_read=1 and its own address.
- Starvation, STARVE_LIMIT=4: I held and D re-requests continuously -> exactly 4 D grants, then I granted on the 5th arbitration, starve_cnt back to 0.
- Reset mid-transaction: rst_n low during SERVE_D before pmem_resp -> pmem_write=0 asynchronously, no resp pulse; after release with no requests, stays IDLE.
- Stale-request guard: D drops request in cycle after d_pmem_resp; RECOVER then IDLE -> no second D transaction issued.
- Spurious pmem_resp in IDLE -> both resp outputs remain 0, no state change.

Source files
------------

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one memory port.
// D-cache wins by default; a starvation counter forces I-cache through.
module cache_arbiter #(
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RECOVER
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     starve_q;
  logic [CW-1:0]     starve_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic              d_pend;
  logic              force_i;
  logic              grant_d;

  assign d_pend  = d_pmem_read | d_pmem_write;
  assign force_i = i_pmem_read && (starve_q == LIMIT);
  assign grant_d = d_pend && !force_i;

  assign starve_inc = (starve_q == LIMIT) ? starve_q
                                          : starve_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q  <= SERVE_D;
            addr_q   <= d_pmem_address;
            wdata_q  <= d_pmem_wdata;
            rd_q     <= ~d_pmem_write;
            wr_q     <= d_pmem_write;
            starve_q <= i_pmem_read ? starve_inc : '0;
          end else if (i_pmem_read) begin
            state_q  <= SERVE_I;
            addr_q   <= i_pmem_address;
            wdata_q  <= '0;
            rd_q     <= 1'b1;
            wr_q     <= 1'b0;
            starve_q <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state_q <= RECOVER;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
          end
        end
        RECOVER: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_pmem_resp = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp = (state_q == SERVE_D) & pmem_resp;

  // Data passes straight through; forced low so reset clears every output.
  assign i_pmem_rdata = rst_n ? pmem_rdata : '0;
  assign d_pmem_rdata = rst_n ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level arbitration model.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam int SL = 4;

  logic          clk;
  logic          rst_n;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int total;
  int bad;

  cache_arbiter #(
    .LINE_W(LW),
    .ADDR_W(AW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_pmem_read(i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata),
    .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read),
    .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata),
    .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_inputs();
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    clear_inputs();
    pmem_resp  = 1'b1;
    pmem_rdata = {8{32'hFEED_BEEF}};
    #1;
    total++;
    if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
    end
    total++;
    if (pmem_address !== '0 || pmem_wdata !== '0) begin
      bad++;
      $display("FAIL reset_latch: addr %h wdata %h want 0",
               pmem_address, pmem_wdata);
    end
    total++;
    if (i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
      bad++;
      $display("FAIL reset_rdata: i %h d %h want 0", i_pmem_rdata, d_pmem_rdata);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle c%0d: rd %b wr %b want 0 0",
                 c, pmem_read, pmem_write);
      end
    end
  endtask

  task automatic test_single_i();
    logic [LW-1:0] a;
    bit dseen;
    a     = {8{32'hA5A5_0001}};
    dseen = 1'b0;
    do_reset();
    @(negedge clk);
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0040;
    #1;
    total++;
    if (pmem_read !== 1'b0) begin
      bad++;
      $display("FAIL single_i c0 rd: got %b want 0", pmem_read);
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 3) i_pmem_address = 32'hDEAD_0000;
      if (c == 6) i_pmem_read = 1'b0;
      pmem_resp  = (c == 5);
      pmem_rdata = (c == 5) ? a : rnd_line();
      #1;
      if (d_pmem_resp) dseen = 1'b1;
      total++;
      if (pmem_read !== (c <= 5) || pmem_write !== 1'b0) begin
        bad++;
        $display("FAIL single_i c%0d req: rd %b wr %b want %b 0",
                 c, pmem_read, pmem_write, (c <= 5));
      end
      if (c <= 5) begin
        total++;
        if (pmem_address !== 32'h40) begin
          bad++;
          $display("FAIL single_i c%0d addr: got %h want 40", c, pmem_address);
        end
      end
      total++;
      if (i_pmem_resp !== (c == 5)) begin
        bad++;
        $display("FAIL single_i c%0d iresp: got %b want %b",
                 c, i_pmem_resp, (c == 5));
      end
      if (c == 5) begin
        total++;
        if (i_pmem_rdata !== a) begin
          bad++;
          $display("FAIL single_i rdata: got %h want %h", i_pmem_rdata, a);
        end
      end
    end
    pmem_resp = 1'b0;
    total++;
    if (dseen) begin
      bad++;
      $display("FAIL single_i dresp: got 1 want never");
    end
  endtask

  task automatic test_priority();
    logic [LW-1:0] b;
    b = {8{32'h0B0B_1234}};
    do_reset();
    @(negedge clk);
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0100;
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_0080;
    d_pmem_wdata   = b;
    @(negedge clk);
    #1;
    total++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 ||
        pmem_address !== 32'h80 || pmem_wdata !== b) begin
      bad++;
      $display("FAIL prio_d: wr %b rd %b addr %h want 1 0 80",
               pmem_write, pmem_read, pmem_address);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    total++;
    if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin
      bad++;
      $display("FAIL prio_dresp: d %b i %b want 1 0", d_pmem_resp, i_pmem_resp);
    end
    @(negedge clk);
    pmem_resp    = 1'b0;
    d_pmem_write = 1'b0;
    for (int c = 3; c <= 4; c++) begin
      #1;
      total++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
        bad++;
        $display("FAIL prio_gap c%0d: rd %b wr %b want 0 0",
                 c, pmem_read, pmem_write);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 ||
        pmem_address !== 32'h100) begin
      bad++;
      $display("FAIL prio_i: rd %b wr %b addr %h want 1 0 100",
               pmem_read, pmem_write, pmem_address);
    end
    clear_inputs();
  endtask

  task automatic test_starvation();
    int  n;
    bit  is_i;
    do_reset();
    @(negedge clk);
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_1000;
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_2000;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      @(negedge clk);
      pmem_resp  = pmem_read | pmem_write;
      pmem_rdata = rnd_line();
      #1;
      if (pmem_resp) begin
        is_i = (pmem_address == 32'h1000);
        total++;
        if (is_i != (n % 5 == 4)) begin
          bad++;
          $display("FAIL starve grant%0d: i_granted %b want %b",
                   n, is_i, (n % 5 == 4));
        end
        total++;
        if (i_pmem_resp !== is_i || d_pmem_resp !== !is_i) begin
          bad++;
          $display("FAIL starve resp%0d: i %b d %b want %b %b",
                   n, i_pmem_resp, d_pmem_resp, is_i, !is_i);
        end
        n++;
      end
    end
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL starve timeout: grants %0d want 10", n);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_0300;
    d_pmem_wdata   = {8{32'hC0C0_C0C0}};
    @(negedge clk);
    #1;
    total++;
    if (pmem_write !== 1'b1) begin
      bad++;
      $display("FAIL rmid pre: wr %b want 1", pmem_write);
    end
    #2;
    rst_n     = 1'b0;
    pmem_resp = 1'b1;
    #1;
    total++;
    if (pmem_write !== 1'b0 || pmem_address !== '0 || pmem_wdata !== '0 ||
        d_pmem_resp !== 1'b0 || i_pmem_resp !== 1'b0) begin
      bad++;
      $display("FAIL rmid async: wr %b addr %h dresp %b want 0 0 0",
               pmem_write, pmem_address, d_pmem_resp);
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      total++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
        bad++;
        $display("FAIL rmid idle c%0d: got %b want 0000", c,
                 {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
      end
    end
  endtask

  task automatic test_stale();
    int reqs;
    do_reset();
    @(negedge clk);
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_0500;
    @(negedge clk);
    #1;
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h500) begin
      bad++;
      $display("FAIL stale req: rd %b addr %h want 1 500", pmem_read, pmem_address);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    total++;
    if (d_pmem_resp !== 1'b1) begin
      bad++;
      $display("FAIL stale resp: got %b want 1", d_pmem_resp);
    end
    @(negedge clk);
    pmem_resp   = 1'b0;
    d_pmem_read = 1'b0;
    reqs = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (pmem_read | pmem_write) reqs++;
      @(negedge clk);
    end
    total++;
    if (reqs != 0) begin
      bad++;
      $display("FAIL stale regrant: %0d request cycles want 0", reqs);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      pmem_resp  = 1'b1;
      pmem_rdata = rnd_line();
      #1;
      total++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
        bad++;
        $display("FAIL spur c%0d: got %b want 0000", c,
                 {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
      end
    end
    @(negedge clk);
    pmem_resp      = 1'b0;
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0700;
    @(negedge clk);
    #1;
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h700 || i_pmem_resp !== 1'b0) begin
      bad++;
      $display("FAIL spur after: rd %b addr %h iresp %b want 1 700 0",
               pmem_read, pmem_address, i_pmem_resp);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    bit            m_busy, m_bub, m_isi, m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wd;
    int            m_st;
    bit            i_done, d_done, mem_act;
    int            mem_left, op;
    bit            e_rd, e_wr, e_ir, e_dr;
    do_reset();
    m_busy = 0; m_bub = 0; m_isi = 0; m_wr = 0; m_st = 0;
    m_addr = '0; m_wd = '0;
    i_done = 0; d_done = 0; mem_act = 0; mem_left = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (i_done) begin
        i_pmem_read = 1'b0;
        i_done      = 0;
      end else if (!i_pmem_read) begin
        if ($urandom_range(0, 2) == 0) begin
          i_pmem_read    = 1'b1;
          i_pmem_address = $urandom;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        i_pmem_address = $urandom;
      end
      if (d_done) begin
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        d_done       = 0;
      end else if (!(d_pmem_read | d_pmem_write)) begin
        if ($urandom_range(0, 1) == 0) begin
          op             = $urandom_range(0, 5);
          d_pmem_read    = (op < 3) || (op == 5);
          d_pmem_write   = (op >= 3);
          d_pmem_address = $urandom;
          d_pmem_wdata   = rnd_line();
        end
      end else if ($urandom_range(0, 7) == 0) begin
        d_pmem_address = $urandom;
        d_pmem_wdata   = rnd_line();
      end
      pmem_rdata = rnd_line();
      if (pmem_read | pmem_write) begin
        if (!mem_act) begin
          mem_act  = 1;
          mem_left = $urandom_range(0, 3);
        end
        pmem_resp = (mem_left == 0);
        if (mem_left > 0) mem_left--;
      end else begin
        mem_act   = 0;
        pmem_resp = ($urandom_range(0, 7) == 0);
      end
      #1;
      e_rd = m_busy && !m_wr;
      e_wr = m_busy && m_wr;
      e_ir = m_busy && m_isi && pmem_resp;
      e_dr = m_busy && !m_isi && pmem_resp;
      total++;
      if (pmem_read !== e_rd || pmem_write !== e_wr) begin
        bad++;
        $display("FAIL rand c%0d req: rd %b wr %b want %b %b",
                 cyc, pmem_read, pmem_write, e_rd, e_wr);
      end
      if (m_busy) begin
        total++;
        if (pmem_address !== m_addr) begin
          bad++;
          $display("FAIL rand c%0d addr: got %h want %h", cyc, pmem_address, m_addr);
        end
        if (m_wr) begin
          total++;
          if (pmem_wdata !== m_wd) begin
            bad++;
            $display("FAIL rand c%0d wdata: got %h want %h", cyc, pmem_wdata, m_wd);
          end
        end
      end
      total++;
      if (i_pmem_resp !== e_ir || d_pmem_resp !== e_dr) begin
        bad++;
        $display("FAIL rand c%0d resp: i %b d %b want %b %b",
                 cyc, i_pmem_resp, d_pmem_resp, e_ir, e_dr);
      end
      if (e_ir || e_dr) begin
        total++;
        if ((e_ir ? i_pmem_rdata : d_pmem_rdata) !== pmem_rdata) begin
          bad++;
          $display("FAIL rand c%0d rdata: i %h d %h want %h",
                   cyc, i_pmem_rdata, d_pmem_rdata, pmem_rdata);
        end
      end
      if (i_pmem_resp) i_done = 1;
      if (d_pmem_resp) d_done = 1;
      if (m_busy) begin
        if (pmem_resp) begin
          m_busy = 0;
          m_bub  = 1;
        end
      end else if (m_bub) begin
        m_bub = 0;
      end else if ((d_pmem_read | d_pmem_write) &&
                   !(i_pmem_read && m_st == SL)) begin
        m_busy = 1;
        m_isi  = 0;
        m_wr   = d_pmem_write;
        m_addr = d_pmem_address;
        m_wd   = d_pmem_wdata;
        m_st   = i_pmem_read ? ((m_st < SL) ? m_st + 1 : SL) : 0;
      end else if (i_pmem_read) begin
        m_busy = 1;
        m_isi  = 1;
        m_wr   = 0;
        m_addr = i_pmem_address;
        m_st   = 0;
      end
    end
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_i();
    test_priority();
    test_starvation();
    test_reset_mid();
    test_stale();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
